// File: rtl/vga_timing_gen_if.sv
// ----------------------------------------------------------------------------
// vga_timing_gen_if
//   Raster timing bundle between the timing generator and the renderers.
//
//   Signals:
//     pix_ce      pixel advance enable (driven by the consumer/clock logic)
//     DrawX       current horizontal count
//     DrawY       current vertical count
//     blank       1 = visible area, 0 = blanking
//     hs, vs      horizontal / vertical sync, active low
//     line_start  high while DrawX == 0
//     frame_start high while DrawX == 0 and DrawY == 0
//     frame_count frames started since reset, wraps 255 -> 0
//
//   Modports:
//     master  the timing generator (drives the raster outputs)
//     slave   the renderer side (drives pix_ce, samples the raster)
//
//   Handshake: there is no valid/ready pair. pix_ce acts as a qualifier;
//   every output is a register that changes only after a clock edge that
//   sampled pix_ce high, and holds otherwise.
// ----------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic       pix_ce;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        input  pix_ce,
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        output pix_ce,
        input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator (default 640x480 @ 60 Hz, 800x525 total).
//   Produces pixel coordinates, blank, active-low syncs, line/frame strobes
//   and an 8-bit frame counter. Every output is a register loaded from the
//   decode of the *next* position, so sync, blank and coordinates are
//   mutually aligned with no pipeline skew.
//
//   Ports:
//     vga_clk  pixel-domain clock
//     reset_n  asynchronous active-low reset
//     vif      vga_timing_gen_if.master (pix_ce in, raster outputs out)
//
//   After reset the position is (H_TOTAL-1, V_TOTAL-1), so the first
//   enabled pixel lands on (0,0) and counts as a frame start.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counters are 10 bits wide; larger rasters cannot be represented.
    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds can reach 1024, so compare in 11 bits.
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;

    logic [10:0] x_ext;
    logic [10:0] y_ext;

    // Next position and its decode; only committed on a pix_ce edge.
    always_comb begin
        h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end

        x_ext = {1'b0, h_d};
        y_ext = {1'b0, v_d};

        blank_d       = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
        hs_d          = !((x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END));
        vs_d          = !((y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END));
        line_start_d  = (h_d == 10'd0);
        frame_start_d = (h_d == 10'd0) && (v_d == 10'd0);
        frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            blank_q       <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else if (vif.pix_ce) begin
            h_q           <= h_d;
            v_q           <= v_d;
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign vif.DrawX       = h_q;
    assign vif.DrawY       = v_q;
    assign vif.blank       = blank_q;
    assign vif.hs          = hs_q;
    assign vif.vs          = vs_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Two instances share clock and reset:
//     dut_d  default 640x480 timing (800x525) for line-level checks
//     dut_s  small raster for frame-level checks within a short run:
//            H 10/2/4/4  -> H_TOTAL 20, hs low for x in 12..15
//            V  6/1/2/1  -> V_TOTAL 10, vs low for y in 7..8
//            one frame = 200 enabled pixels
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   at that same point, well away from the active edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if vif_d ();
    vga_timing_gen_if vif_s ();

    vga_timing_gen dut_d (
        .vga_clk (clk),
        .reset_n (rst_n),
        .vif     (vif_d.master)
    );

    vga_timing_gen #(
        .H_VISIBLE (10), .H_FRONT (2), .H_SYNC (4), .H_BACK (4),
        .V_VISIBLE (6),  .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) dut_s (
        .vga_clk (clk),
        .reset_n (rst_n),
        .vif     (vif_s.master)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the last rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_d(input string tag);
        chk({tag, "_d_x"},  32'(vif_d.DrawX), 799);
        chk({tag, "_d_y"},  32'(vif_d.DrawY), 524);
        chk({tag, "_d_blank"}, 32'(vif_d.blank), 0);
        chk({tag, "_d_hs"}, 32'(vif_d.hs), 1);
        chk({tag, "_d_vs"}, 32'(vif_d.vs), 1);
        chk({tag, "_d_ls"}, 32'(vif_d.line_start), 0);
        chk({tag, "_d_fs"}, 32'(vif_d.frame_start), 0);
        chk({tag, "_d_fc"}, 32'(vif_d.frame_count), 0);
    endtask

    task automatic chk_reset_s(input string tag);
        chk({tag, "_s_x"},  32'(vif_s.DrawX), 19);
        chk({tag, "_s_y"},  32'(vif_s.DrawY), 9);
        chk({tag, "_s_blank"}, 32'(vif_s.blank), 0);
        chk({tag, "_s_hs"}, 32'(vif_s.hs), 1);
        chk({tag, "_s_vs"}, 32'(vif_s.vs), 1);
        chk({tag, "_s_fs"}, 32'(vif_s.frame_start), 0);
        chk({tag, "_s_fc"}, 32'(vif_s.frame_count), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hs_low;
        int hs_first;
        int hs_last;
        int ls_hi;
        int vs_low;
        int fs_hi;
        int blank_hi;
        int blank_bad;
        logic [31:0] exp_q[$];

        rst_n        = 1'b0;
        vif_d.pix_ce = 1'b0;
        vif_s.pix_ce = 1'b0;
        step(3);
        chk_reset_d("rst");
        chk_reset_s("rst");

        // ---- first pixels after reset release (default raster) ----
        rst_n        = 1'b1;
        vif_d.pix_ce = 1'b1;
        step(1);
        chk("first_x",  32'(vif_d.DrawX), 0);
        chk("first_y",  32'(vif_d.DrawY), 0);
        chk("first_blank", 32'(vif_d.blank), 1);
        chk("first_fs", 32'(vif_d.frame_start), 1);
        chk("first_ls", 32'(vif_d.line_start), 1);
        chk("first_fc", 32'(vif_d.frame_count), 1);
        chk("first_hs", 32'(vif_d.hs), 1);
        step(1);
        chk("second_x",  32'(vif_d.DrawX), 1);
        chk("second_fs", 32'(vif_d.frame_start), 0);
        chk("second_ls", 32'(vif_d.line_start), 0);

        // ---- line timing, continuous enable ----
        step(638);
        chk("x639", 32'(vif_d.DrawX), 639);
        chk("x639_blank", 32'(vif_d.blank), 1);
        step(1);
        chk("x640", 32'(vif_d.DrawX), 640);
        chk("x640_blank", 32'(vif_d.blank), 0);

        hs_low = 0; hs_first = -1; hs_last = -1;
        for (int k = 0; k < 159; k++) begin
            step(1);
            if (vif_d.hs == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(vif_d.DrawX);
                hs_last = int'(vif_d.DrawX);
            end
        end
        chk("x799", 32'(vif_d.DrawX), 799);
        chk("hs_low_clocks", 32'(hs_low), 96);
        chk("hs_first_x", 32'(hs_first), 656);
        chk("hs_last_x",  32'(hs_last), 751);
        step(1);
        chk("wrap_x",  32'(vif_d.DrawX), 0);
        chk("wrap_y",  32'(vif_d.DrawY), 1);
        chk("wrap_ls", 32'(vif_d.line_start), 1);
        chk("wrap_fs", 32'(vif_d.frame_start), 0);
        chk("wrap_blank", 32'(vif_d.blank), 1);
        chk("wrap_fc", 32'(vif_d.frame_count), 1);
        chk("wrap_vs", 32'(vif_d.vs), 1);

        // ---- pix_ce toggling 1,0,1,0 over one full line ----
        // Expected DrawX after the first four clocks: 1,1,2,2.
        exp_q.push_back(1); exp_q.push_back(1);
        exp_q.push_back(2); exp_q.push_back(2);
        hs_low = 0; ls_hi = 0;
        for (int k = 0; k < 1600; k++) begin
            vif_d.pix_ce = (k % 2 == 0);
            step(1);
            if (exp_q.size() > 0) chk("toggle_x", 32'(vif_d.DrawX), exp_q.pop_front());
            if (vif_d.hs == 1'b0) hs_low++;
            if (vif_d.line_start) ls_hi++;
        end
        chk("toggle_end_x", 32'(vif_d.DrawX), 0);
        chk("toggle_end_y", 32'(vif_d.DrawY), 2);
        chk("toggle_hs_clocks", 32'(hs_low), 192);
        chk("toggle_ls_clocks", 32'(ls_hi), 2);
        vif_d.pix_ce = 1'b0;

        // ---- small raster: held at reset position while pix_ce was low ----
        chk_reset_s("hold");

        // frame_start held for a two-clock pixel period
        vif_s.pix_ce = 1'b1;
        step(1);
        chk("s_first_x",  32'(vif_s.DrawX), 0);
        chk("s_first_fs", 32'(vif_s.frame_start), 1);
        chk("s_first_fc", 32'(vif_s.frame_count), 1);
        vif_s.pix_ce = 1'b0;
        step(1);
        chk("s_fs_held", 32'(vif_s.frame_start), 1);
        chk("s_x_held",  32'(vif_s.DrawX), 0);

        // ---- one full frame, continuous enable ----
        vif_s.pix_ce = 1'b1;
        vs_low = 0; fs_hi = 0; blank_hi = 0; blank_bad = 0;
        for (int k = 0; k < 200; k++) begin
            step(1);
            if (vif_s.vs == 1'b0) vs_low++;
            if (vif_s.frame_start) fs_hi++;
            if (vif_s.blank) begin
                blank_hi++;
                if (vif_s.DrawY >= 10'd6) blank_bad++;
            end
            if (vif_s.vs == 1'b0 && (vif_s.DrawY < 10'd7 || vif_s.DrawY > 10'd8)) blank_bad++;
        end
        chk("s_frame_x",  32'(vif_s.DrawX), 0);
        chk("s_frame_y",  32'(vif_s.DrawY), 0);
        chk("s_frame_fs", 32'(vif_s.frame_start), 1);
        chk("s_frame_fc", 32'(vif_s.frame_count), 2);
        chk("s_vs_clocks", 32'(vs_low), 40);
        chk("s_fs_per_frame", 32'(fs_hi), 1);
        chk("s_blank_clocks", 32'(blank_hi), 60);
        chk("s_region_bad", 32'(blank_bad), 0);

        // ---- asynchronous reset mid-frame at (3,5) ----
        step(103);
        chk("s_mid_x", 32'(vif_s.DrawX), 3);
        chk("s_mid_y", 32'(vif_s.DrawY), 5);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_s("async");
        chk_reset_d("async");
        rst_n = 1'b1;
        step(1);
        chk("s_rel_x",  32'(vif_s.DrawX), 0);
        chk("s_rel_y",  32'(vif_s.DrawY), 0);
        chk("s_rel_fs", 32'(vif_s.frame_start), 1);
        chk("s_rel_fc", 32'(vif_s.frame_count), 1);
        chk("d_rel_held_x", 32'(vif_d.DrawX), 799);

        // ---- frame counter wrap 255 -> 0 ----
        step(254 * 200);
        chk("fc255_x",  32'(vif_s.DrawX), 0);
        chk("fc255_y",  32'(vif_s.DrawY), 0);
        chk("fc255",    32'(vif_s.frame_count), 255);
        step(199);
        chk("pre_wrap_x", 32'(vif_s.DrawX), 19);
        chk("pre_wrap_y", 32'(vif_s.DrawY), 9);
        chk("pre_wrap_fc", 32'(vif_s.frame_count), 255);
        step(1);
        chk("fc_wrap",    32'(vif_s.frame_count), 0);
        chk("fc_wrap_fs", 32'(vif_s.frame_start), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
